axi_lite_sram_slave: RTL and testbench



---
 rtl/axi_pkg.sv | 19 +
 rtl/sram_bank.sv | 31 +++
 rtl/axi_lite_sram_slave.sv | 172 +++++++++++++++++
 tb/tb_axi_lite_sram_slave.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4-Lite definitions: default bus widths, response codes and the
// slave handshake FSM state encoding.
package axi_pkg;

  localparam int unsigned AXI_ADDR_BITS = 32;
  localparam int unsigned AXI_DATA_BITS = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_RESP,
    ST_WR_COLLECT,
    ST_WR_RESP
  } axi_slv_state_e;

endpackage

// File: rtl/sram_bank.sv
// Single-port SRAM with per-byte write enables and a registered read port.
// The read register only changes on a read enable, so it holds its word.
module sram_bank #(
  parameter int unsigned DATA_BITS   = 32,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           re,
  input  logic [DATA_BITS/8-1:0]         we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [DATA_BITS-1:0]           wdata,
  output logic [DATA_BITS-1:0]           rdata
);

  logic [DATA_BITS-1:0] mem [DEPTH_WORDS];

  // NOTE: the array has no reset branch so it maps onto plain SRAM macros;
  // its contents survive a reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_BITS / 8; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite slave in front of a byte-writable SRAM: one transaction at a time,
// fair read/write arbitration, programmable read latency, SLVERR out of range.
module axi_lite_sram_slave
  import axi_pkg::*;
#(
  parameter int unsigned          ADDR_BITS    = AXI_ADDR_BITS,
  parameter int unsigned          DATA_BITS    = AXI_DATA_BITS,
  parameter int unsigned          DEPTH_WORDS  = 1024,
  parameter logic [ADDR_BITS-1:0] BASE_ADDR    = 32'h1000_0000,
  parameter int unsigned          READ_LATENCY = 2
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic [ADDR_BITS-1:0]   ARADDR,
  input  logic                   ARVALID,
  output logic                   ARREADY,
  output logic [DATA_BITS-1:0]   RDATA,
  output logic [1:0]             RRESP,
  output logic                   RVALID,
  input  logic                   RREADY,
  input  logic [ADDR_BITS-1:0]   AWADDR,
  input  logic                   AWVALID,
  output logic                   AWREADY,
  input  logic [DATA_BITS-1:0]   WDATA,
  input  logic [DATA_BITS/8-1:0] WSTRB,
  input  logic                   WVALID,
  output logic                   WREADY,
  output logic [1:0]             BRESP,
  output logic                   BVALID,
  input  logic                   BREADY
);

  localparam int unsigned STRB_BITS = DATA_BITS / 8;
  localparam int unsigned LSB       = $clog2(STRB_BITS);
  localparam int unsigned IDX_BITS  = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_BITS-1:0] SPAN = ADDR_BITS'(DEPTH_WORDS * STRB_BITS);
  localparam int unsigned CNT_BITS  = (READ_LATENCY > 2) ? $clog2(READ_LATENCY - 1) : 1;
  localparam logic [CNT_BITS-1:0] CNT_LOAD =
    CNT_BITS'((READ_LATENCY > 2) ? READ_LATENCY - 2 : 0);

  function automatic logic out_of_range(input logic [ADDR_BITS-1:0] addr);
    logic [ADDR_BITS-1:0] off;
    off = addr - BASE_ADDR;
    return (addr < BASE_ADDR) || (off >= SPAN);
  endfunction

  function automatic logic [IDX_BITS-1:0] word_index(input logic [ADDR_BITS-1:0] addr);
    return IDX_BITS'((addr - BASE_ADDR) >> LSB);
  endfunction

  axi_slv_state_e         state_q, state_d;
  logic                   prio_q;
  logic [CNT_BITS-1:0]    cnt_q;
  logic                   aw_got_q, w_got_q;
  logic [ADDR_BITS-1:0]   aw_addr_q;
  logic [DATA_BITS-1:0]   wdata_q;
  logic [STRB_BITS-1:0]   wstrb_q;
  logic                   rd_err_q;
  logic [1:0]             bresp_q;

  logic                   ar_hs, aw_hs, w_hs, wr_req, wr_commit, wr_err;
  logic [ADDR_BITS-1:0]   wr_addr;
  logic [DATA_BITS-1:0]   wr_data, bank_rdata;
  logic [STRB_BITS-1:0]   wr_strb, bank_we;
  logic [IDX_BITS-1:0]    bank_addr;

  assign wr_req = AWVALID || WVALID;
  assign ar_hs  = ARVALID && ARREADY;
  assign aw_hs  = AWVALID && AWREADY;
  assign w_hs   = WVALID && WREADY;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    ARREADY = 1'b0;
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // On a collision prio picks the winner; the loser sees READY low.
        ARREADY = ARVALID && (!wr_req || !prio_q);
        AWREADY = AWVALID && (!ARVALID || prio_q);
        WREADY  = WVALID && (!ARVALID || prio_q);
        if (ARREADY)                state_d = (READ_LATENCY == 1) ? ST_RD_RESP : ST_RD_WAIT;
        else if (AWREADY && WREADY) state_d = ST_WR_RESP;
        else if (AWREADY || WREADY) state_d = ST_WR_COLLECT;
      end
      ST_RD_WAIT:    if (cnt_q == '0) state_d = ST_RD_RESP;
      ST_RD_RESP:    if (RREADY) state_d = ST_IDLE;
      ST_WR_COLLECT: begin
        AWREADY = AWVALID && !aw_got_q;
        WREADY  = WVALID && !w_got_q;
        if ((aw_got_q || AWREADY) && (w_got_q || WREADY)) state_d = ST_WR_RESP;
      end
      ST_WR_RESP:    if (BREADY) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
    if (ARESET) begin
      ARREADY = 1'b0;
      AWREADY = 1'b0;
      WREADY  = 1'b0;
    end
  end

  // A channel handshaking on the commit edge bypasses its capture register.
  assign wr_addr   = aw_hs ? AWADDR : aw_addr_q;
  assign wr_data   = w_hs ? WDATA : wdata_q;
  assign wr_strb   = w_hs ? WSTRB : wstrb_q;
  assign wr_err    = out_of_range(wr_addr);
  assign wr_commit = (state_d == ST_WR_RESP) && (state_q != ST_WR_RESP) && !ARESET;
  assign bank_we   = (wr_commit && !wr_err) ? wr_strb : '0;
  assign bank_addr = ar_hs ? word_index(ARADDR) : word_index(wr_addr);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= ST_IDLE;
      prio_q    <= 1'b0;
      cnt_q     <= '0;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      aw_addr_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rd_err_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && ARVALID && wr_req) prio_q <= ~prio_q;
      if (ar_hs) begin
        cnt_q    <= CNT_LOAD;
        rd_err_q <= out_of_range(ARADDR);
      end else if (state_q == ST_RD_WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_BITS'(1);
      end
      if (aw_hs) begin
        aw_got_q  <= 1'b1;
        aw_addr_q <= AWADDR;
      end
      if (w_hs) begin
        w_got_q <= 1'b1;
        wdata_q <= WDATA;
        wstrb_q <= WSTRB;
      end
      if (wr_commit) begin
        aw_got_q <= 1'b0;
        w_got_q  <= 1'b0;
        bresp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  sram_bank #(
    .DATA_BITS  (DATA_BITS),
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_bank (
    .clk  (ACLK),
    .rst  (ARESET),
    .re   (ar_hs),
    .we   (bank_we),
    .addr (bank_addr),
    .wdata(wr_data),
    .rdata(bank_rdata)
  );

  assign RVALID = (state_q == ST_RD_RESP);
  assign BVALID = (state_q == ST_WR_RESP);
  assign RDATA  = rd_err_q ? '0 : bank_rdata;
  assign RRESP  = rd_err_q ? RESP_SLVERR : RESP_OKAY;
  assign BRESP  = bresp_q;

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Self-checking bench for axi_lite_sram_slave: directed scenarios followed by
// randomized reads/writes checked against a word-array reference model.
module tb_axi_lite_sram_slave;
  import axi_pkg::*;

  localparam int          RL   = 2;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] ARADDR, AWADDR, WDATA, RDATA;
  logic [3:0]  WSTRB;
  logic [1:0]  RRESP, BRESP;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;

  always #5 ACLK = ~ACLK;

  axi_lite_sram_slave #(
    .ADDR_BITS(32), .DATA_BITS(32), .DEPTH_WORDS(1024),
    .BASE_ADDR(BASE), .READ_LATENCY(RL)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] model_mem [int];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  function automatic bit in_range(input logic [31:0] addr);
    return addr >= BASE && addr <= BASE + 32'h0000_0FFF;
  endfunction

  function automatic int widx(input logic [31:0] addr);
    return int'((addr - BASE) >> 2);
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_delay, input int w_delay,
                          input int b_delay, input logic [1:0] exp_resp);
    bit aw_done = 0, w_done = 0, aw_fire, w_fire;
    int cyc = 0;
    AWADDR = addr; WDATA = data; WSTRB = strb;
    while (!(aw_done && w_done) && cyc < 64) begin
      AWVALID = !aw_done && cyc >= aw_delay;
      WVALID  = !w_done && cyc >= w_delay;
      @(negedge ACLK);
      if (AWVALID) check("awready", AWREADY, 1);
      if (WVALID)  check("wready", WREADY, 1);
      check("bvalid_early", BVALID, 0);
      aw_fire = AWVALID && AWREADY;
      w_fire  = WVALID && WREADY;
      tick();
      if (aw_fire) aw_done = 1;
      if (w_fire)  w_done = 1;
      cyc++;
    end
    AWVALID = 0; WVALID = 0;
    check("wr_handshakes", {aw_done, w_done}, 2'b11);
    for (int k = 0; k <= b_delay; k++) begin
      BREADY = (k == b_delay);
      @(negedge ACLK);
      check("bvalid", BVALID, 1);
      check("bresp", BRESP, exp_resp);
      tick();
    end
    BREADY = 0;
    check("bvalid_drop", BVALID, 0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input int r_delay);
    ARADDR = addr; ARVALID = 1;
    @(negedge ACLK);
    check("arready", ARREADY, 1);
    tick();
    ARVALID = 0;
    for (int i = 1; i < RL; i++) begin
      @(negedge ACLK);
      check("rvalid_early", RVALID, 0);
      tick();
    end
    for (int k = 0; k <= r_delay; k++) begin
      RREADY = (k == r_delay);
      @(negedge ACLK);
      check("rvalid", RVALID, 1);
      check("rdata", RDATA, exp_data);
      check("rresp", RRESP, exp_resp);
      tick();
    end
    RREADY = 0;
    check("rvalid_drop", RVALID, 0);
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int awd, input int wd, input int bd);
    logic [31:0] w;
    if (in_range(addr)) begin
      w = model_mem.exists(widx(addr)) ? model_mem[widx(addr)] : 32'h0;
      for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = data[8*b +: 8];
      model_mem[widx(addr)] = w;
      do_write(addr, data, strb, awd, wd, bd, RESP_OKAY);
    end else begin
      do_write(addr, data, strb, awd, wd, bd, RESP_SLVERR);
    end
  endtask

  task automatic model_read(input logic [31:0] addr, input int rd);
    if (in_range(addr)) do_read(addr, model_mem[widx(addr)], RESP_OKAY, rd);
    else                do_read(addr, 32'h0, RESP_SLVERR, rd);
  endtask

  task automatic reset_dut();
    ARESET = 1;
    ARVALID = 0; AWVALID = 0; WVALID = 0; RREADY = 0; BREADY = 0;
    repeat (3) tick();
    ARESET = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int pool [8] = '{0, 1, 4, 8, 9, 100, 1022, 1023};
    logic [31:0] oor [4] = '{32'h1000_1000, 32'h0FFF_FFFC, 32'h0000_0000, 32'hFFFF_FFFC};
    logic [31:0] a, d1, d2;
    ARADDR = 0; AWADDR = 0; WDATA = 0; WSTRB = 0;
    reset_dut();

    // Reset state.
    @(negedge ACLK);
    check("rst_arready", ARREADY, 0);
    check("rst_awready", AWREADY, 0);
    check("rst_wready", WREADY, 0);
    check("rst_rvalid", RVALID, 0);
    check("rst_bvalid", BVALID, 0);
    check("rst_rdata", RDATA, 0);
    check("rst_rresp", RRESP, 0);
    check("rst_bresp", BRESP, 0);
    tick();

    foreach (pool[i]) model_write(BASE + 32'(pool[i] * 4), $urandom, 4'hF, 0, 0, 0);

    // Write/read back, then byte strobes over the same word.
    model_write(32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    do_read(32'h1000_0004, 32'hDEAD_BEEF, RESP_OKAY, 0);
    model_write(32'h1000_0004, 32'h1122_3344, 4'b0101, 0, 0, 0);
    do_read(32'h1000_0004, 32'hDE22_BE44, RESP_OKAY, 0);

    // Split write: W leads AW by 3 cycles, B held off 4 cycles.
    model_write(32'h1000_0010, 32'hCAFE_F00D, 4'hF, 3, 0, 4);
    do_read(32'h1000_0010, 32'hCAFE_F00D, RESP_OKAY, 0);
    model_write(32'h1000_0010, 32'h0BAD_0BAD, 4'h0, 0, 2, 1);
    do_read(32'h1000_0010, 32'hCAFE_F00D, RESP_OKAY, 0);

    // Out of range.
    do_read(32'h1000_1000, 32'h0, RESP_SLVERR, 0);
    do_read(32'h0FFF_FFFC, 32'h0, RESP_SLVERR, 1);
    model_write(32'h0FFF_FFFC, 32'h5555_AAAA, 4'hF, 0, 0, 0);
    model_read(BASE, 0);
    model_read(BASE + 32'h0FFC, 0);

    // Collisions from reset: read wins first, then write wins.
    reset_dut();
    d1 = $urandom; d2 = $urandom;
    ARADDR = BASE + 32'h20; ARVALID = 1;
    AWADDR = BASE + 32'h24; WDATA = d1; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
    @(negedge ACLK);
    check("col1_arready", ARREADY, 1);
    check("col1_awready", AWREADY, 0);
    check("col1_wready", WREADY, 0);
    tick();
    ARVALID = 0;
    @(negedge ACLK);
    check("col1_awready_busy", AWREADY, 0);
    tick();
    for (int k = 0; k <= 5; k++) begin
      RREADY = (k == 5);
      @(negedge ACLK);
      check("col1_rvalid", RVALID, 1);
      check("col1_rdata_hold", RDATA, model_mem[8]);
      check("col1_wready_busy", WREADY, 0);
      tick();
    end
    RREADY = 0;
    @(negedge ACLK);
    check("col1_awready_next", AWREADY, 1);
    check("col1_wready_next", WREADY, 1);
    tick();
    AWVALID = 0; WVALID = 0;
    model_mem[9] = d1;
    BREADY = 1;
    @(negedge ACLK);
    check("col1_bvalid", BVALID, 1);
    check("col1_bresp", BRESP, RESP_OKAY);
    tick();
    BREADY = 0;

    ARADDR = BASE + 32'h24; ARVALID = 1;
    AWADDR = BASE + 32'h20; WDATA = d2; AWVALID = 1; WVALID = 1;
    @(negedge ACLK);
    check("col2_arready", ARREADY, 0);
    check("col2_awready", AWREADY, 1);
    check("col2_wready", WREADY, 1);
    tick();
    AWVALID = 0; WVALID = 0;
    model_mem[8] = d2;
    @(negedge ACLK);
    check("col2_bvalid", BVALID, 1);
    check("col2_arready_busy", ARREADY, 0);
    BREADY = 1;
    tick();
    BREADY = 0;
    @(negedge ACLK);
    check("col2_arready_next", ARREADY, 1);
    tick();
    ARVALID = 0;
    tick();
    RREADY = 1;
    @(negedge ACLK);
    check("col2_rvalid", RVALID, 1);
    check("col2_rdata", RDATA, d1);
    tick();
    RREADY = 0;
    model_read(BASE + 32'h20, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 0) a = oor[$urandom_range(0, 3)];
      else a = BASE + 32'(pool[$urandom_range(0, 7)] * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        model_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3));
      else
        model_read(a, $urandom_range(0, 3));
    end

    // Reset during RD_WAIT drops the read.
    ARADDR = BASE + 32'h4; ARVALID = 1;
    @(negedge ACLK);
    check("mid_arready", ARREADY, 1);
    tick();
    ARVALID = 0;
    ARESET = 1;
    tick();
    ARESET = 0;
    check("mid_arready_0", ARREADY, 0);
    check("mid_awready_0", AWREADY, 0);
    check("mid_wready_0", WREADY, 0);
    check("mid_bvalid_0", BVALID, 0);
    check("mid_rdata_0", RDATA, 0);
    for (int i = 0; i < RL + 2; i++) begin
      @(negedge ACLK);
      check("mid_rvalid_0", RVALID, 0);
      tick();
    end
    model_read(BASE + 32'h4, 0);

    // Reset in WR_COLLECT loses the uncommitted write.
    AWADDR = BASE + 32'h4; AWVALID = 1;
    @(negedge ACLK);
    check("mid_wr_awready", AWREADY, 1);
    tick();
    AWVALID = 0;
    ARESET = 1;
    tick();
    ARESET = 0;
    model_read(BASE + 32'h4, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
